// File: rtl/multiplier_datapath_taint_track.sv
// Shift-add datapath for the sequential multiplier with bitwise taint tracking.
// Holds the multiplicand (md), the multiplier (mr) and a 2*WIDTH+1 bit running
// sum (rs, top bit is the add carry). Each of these has a per-bit taint shadow.
// Load, clear, add and shift strobes come from the multiplier control FSM.
// Every output is a direct register read.
module multiplier_datapath_taint_track #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplicand_in_t,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic [WIDTH-1:0]   multiplier_in_t,
  input  logic               mdld,
  input  logic               mdld_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               productDone,
  input  logic               productDone_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic [WIDTH-1:0]   multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t,
  output logic               product_valid,
  output logic               product_valid_t
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] r_md;
  logic [WIDTH-1:0] r_md_t;
  logic [WIDTH-1:0] r_mr;
  logic [WIDTH-1:0] r_mr_t;
  logic [PW:0]      r_rs;
  logic [PW:0]      r_rs_t;
  logic             r_pv;
  logic             r_pv_t;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sum_t;
  logic [WIDTH-1:0] w_add_c;
  logic [PW:0]      w_rs_nxt;
  logic [PW:0]      w_rs_t_nxt;
  logic             w_rs_strobe_taint;
  logic             w_clr_event;
  logic             w_clr_taint;
  logic             w_pv_t_set;

  // Taint of a W+1 bit sum: every bit from the lowest tainted input bit
  // upwards may be influenced through the carry chain; bits below are clean.
  function automatic logic [WIDTH:0] add_taint_mask(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] m;
    logic           seen;
    m    = '0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      seen = seen | c[i];
      m[i] = seen;
    end
    m[WIDTH] = seen;
    return m;
  endfunction

  // Adder for the upper half of the running sum and its carry-chain taint.
  always_comb begin
    w_sum   = {1'b0, r_rs[PW-1:WIDTH]} + {1'b0, r_md};
    w_add_c = r_rs_t[PW-1:WIDTH] | r_md_t;
    w_sum_t = add_taint_mask(w_add_c);
  end

  // Next running-sum value: clear beats add, add beats shift.
  always_comb begin
    w_rs_nxt = r_rs;
    if (rsclear) begin
      w_rs_nxt = '0;
    end else if (rsload) begin
      w_rs_nxt = {w_sum, r_rs[WIDTH-1:0]};
    end else if (rsshr) begin
      w_rs_nxt = {1'b0, r_rs[PW:1]};
    end else begin
      w_rs_nxt = r_rs;
    end
  end

  // Next running-sum taint: a tainted rs strobe makes every bit suspect,
  // otherwise taint follows the data movement of the selected operation.
  always_comb begin
    w_rs_strobe_taint = rsclear_t | rsload_t | rsshr_t;
    w_rs_t_nxt        = r_rs_t;
    if (w_rs_strobe_taint) begin
      w_rs_t_nxt = '1;
    end else if (rsclear) begin
      w_rs_t_nxt = '0;
    end else if (rsload) begin
      w_rs_t_nxt = {w_sum_t, r_rs_t[WIDTH-1:0]};
    end else if (rsshr) begin
      w_rs_t_nxt = {1'b0, r_rs_t[PW:1]};
    end else begin
      w_rs_t_nxt = r_rs_t;
    end
  end

  // Result-flag event decode; a taint on any clear source or on productDone
  // taints the flag, and only a fully clean clear event untaints it.
  always_comb begin
    w_clr_event = rsclear | mdld | mrld;
    w_clr_taint = rsclear_t | mdld_t | mrld_t;
    w_pv_t_set  = productDone_t | w_clr_taint;
  end

  // Running sum register and its taint shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs   <= '0;
      r_rs_t <= '0;
    end else begin
      r_rs   <= w_rs_nxt;
      r_rs_t <= w_rs_t_nxt;
    end
  end

  // Multiplicand register; a tainted load strobe taints every bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md   <= '0;
      r_md_t <= '0;
    end else begin
      if (mdld) begin
        r_md <= multiplicand_in;
      end else begin
        r_md <= r_md;
      end
      if (mdld_t) begin
        r_md_t <= '1;
      end else if (mdld) begin
        r_md_t <= multiplicand_in_t;
      end else begin
        r_md_t <= r_md_t;
      end
    end
  end

  // Multiplier register, read back by the FSM each SHIFT state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mr   <= '0;
      r_mr_t <= '0;
    end else begin
      if (mrld) begin
        r_mr <= multiplier_in;
      end else begin
        r_mr <= r_mr;
      end
      if (mrld_t) begin
        r_mr_t <= '1;
      end else if (mrld) begin
        r_mr_t <= multiplier_in_t;
      end else begin
        r_mr_t <= r_mr_t;
      end
    end
  end

  // Product-valid flag (clear wins over set) and its taint.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv   <= 1'b0;
      r_pv_t <= 1'b0;
    end else begin
      if (w_clr_event) begin
        r_pv <= 1'b0;
      end else if (productDone) begin
        r_pv <= 1'b1;
      end else begin
        r_pv <= r_pv;
      end
      if (w_pv_t_set) begin
        r_pv_t <= 1'b1;
      end else if (w_clr_event) begin
        r_pv_t <= 1'b0;
      end else begin
        r_pv_t <= r_pv_t;
      end
    end
  end

  assign multiplierReg   = r_mr;
  assign multiplierReg_t = r_mr_t;
  assign product         = r_rs[PW-1:0];
  assign product_t       = r_rs_t[PW-1:0];
  assign product_valid   = r_pv;
  assign product_valid_t = r_pv_t;

endmodule
